// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-sequencer state encoding and default widths.
// Pure declarations, no logic; imported by the memory fetch path.
package cpu_pkg;

    localparam int DEF_ADDR_W  = 15;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/mem_fetch_seq.sv
// Byte-serial memory fetch into the MDR: reads 1..4 consecutive bytes, one MDR write per byte.
// Latency: done pulses 2N+1 cycles after start for N bytes with zero memory wait.
// Backpressure: stalls in RD until mem_ready, gives up with sticky err after TIMEOUT cycles.
module mem_fetch_seq
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [1:0]        len,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [DATA_W-1:0] mdr_data,
    output logic              mdr_we,
    output logic              mdr_shift,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    fetch_state_t      state_q,     state_d;
    logic [ADDR_W-1:0] cur_addr_q,  cur_addr_d;
    logic [1:0]        remaining_q, remaining_d;
    logic [WAIT_W-1:0] wait_q,      wait_d;
    logic [DATA_W-1:0] mdr_data_q,  mdr_data_d;
    logic              not_first_q, not_first_d;
    logic              err_q,       err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            wait_q      <= '0;
            mdr_data_q  <= '0;
            not_first_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            wait_q      <= wait_d;
            mdr_data_q  <= mdr_data_d;
            not_first_q <= not_first_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        wait_d      = wait_q;
        mdr_data_d  = mdr_data_q;
        not_first_d = not_first_q;
        err_d       = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_addr_d  = addr_in;
                    remaining_d = len;
                    wait_d      = '0;
                    not_first_d = 1'b0;
                    err_d       = 1'b0;
                    state_d     = ST_RD;
                end
            end
            ST_RD: begin
                if (mem_ready) begin
                    mdr_data_d = mem_rdata;
                    wait_d     = '0;
                    state_d    = ST_LOAD;
                end else if (wait_q == WAIT_LAST) begin
                    // Abandon the whole fetch; bytes already loaded stay in the MDR.
                    wait_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_LOAD: begin
                not_first_d = 1'b1;
                if (remaining_q == 2'd0) begin
                    state_d = ST_DONE;
                end else begin
                    remaining_d = remaining_q - 2'd1;
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    state_d     = ST_RD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode the state register only, so no input reaches an output combinationally.
    always_comb begin
        mem_addr  = cur_addr_q;
        mem_rd    = (state_q == ST_RD);
        mdr_data  = mdr_data_q;
        mdr_we    = (state_q == ST_LOAD);
        mdr_shift = (state_q == ST_LOAD) && not_first_q;
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        err       = err_q;
    end

endmodule

// File: tb/tb_mem_fetch_seq.sv
// Bench for mem_fetch_seq: directed table, hand-written reset/err sequences, randomized fetches.
module tb_mem_fetch_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [14:0] addr_in;
    logic [1:0]  len;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic [14:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mdr_data;
    logic        mdr_we;
    logic        mdr_shift;
    logic        busy;
    logic        done;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mem [32768];

    always #5 clk = ~clk;

    mem_fetch_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .addr_in   (addr_in),
        .len       (len),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mdr_data  (mdr_data),
        .mdr_we    (mdr_we),
        .mdr_shift (mdr_shift),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: cycle k is the k-th cycle after the start-sampling edge.
    // A byte with delay d is read d cycles after its read begins; d >= 15 never arrives.
    task automatic model(input logic [1:0] l, input int dly[4],
                         output int we_cyc[4], output int n_we, output int done_cyc,
                         output logic exp_err);
        int t;
        t       = 1;
        n_we    = 0;
        exp_err = 1'b0;
        we_cyc  = '{0, 0, 0, 0};
        for (int i = 0; i <= int'(l); i++) begin
            if (dly[i] >= 15) begin
                t       = t + 15;
                exp_err = 1'b1;
                break;
            end
            we_cyc[i] = t + dly[i] + 1;
            n_we++;
            t = t + dly[i] + 2;
        end
        done_cyc = t;
    endtask

    task automatic run_fetch(input logic [14:0] a, input logic [1:0] l, input int dly[4],
                             input bit noise, output int done_at, output logic err_at);
        int   we_cyc[4];
        int   n_we, done_cyc, rd_idx, rd_wait, we_idx;
        logic exp_err;
        logic [14:0] ea;
        model(l, dly, we_cyc, n_we, done_cyc, exp_err);
        done_at = -1;
        err_at  = 1'b0;
        rd_idx  = 0;
        rd_wait = 0;
        we_idx  = 0;
        @(negedge clk);
        start     = 1'b1;
        addr_in   = a;
        len       = l;
        mem_ready = 1'b0;
        for (int cyc = 1; cyc <= done_cyc + 4; cyc++) begin
            @(negedge clk);
            start     = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            addr_in   = 15'($urandom);
            len       = 2'($urandom);
            mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = 8'($urandom);
            check("busy", busy, 1);
            if (cyc == 1) check("err_cleared_by_start", err, 0);
            if (mem_rd) begin
                check("rd_in_range", rd_idx <= int'(l), 1);
                if (rd_idx <= int'(l)) begin
                    ea = a + 15'(rd_idx);
                    check($sformatf("rd_addr[%0d]", rd_idx), mem_addr, ea);
                    if (rd_wait == dly[rd_idx]) begin
                        mem_ready = 1'b1;
                        mem_rdata = mem[mem_addr];
                        rd_idx++;
                        rd_wait = 0;
                    end else begin
                        mem_ready = 1'b0;
                        rd_wait++;
                    end
                end
            end
            if (mdr_we) begin
                if (we_idx < n_we) begin
                    ea = a + 15'(we_idx);
                    check($sformatf("we_cycle[%0d]", we_idx), cyc, we_cyc[we_idx]);
                    check($sformatf("mdr_data[%0d]", we_idx), mdr_data, mem[ea]);
                    check($sformatf("mdr_shift[%0d]", we_idx), mdr_shift, we_idx > 0);
                end else begin
                    check("extra_mdr_we", we_idx + 1, n_we);
                end
                we_idx++;
            end
            if (done) begin
                done_at = cyc;
                err_at  = err;
                start   = 1'b0;
                check("done_cycle", cyc, done_cyc);
                check("err_at_done", err, exp_err);
                check("we_count", we_idx, n_we);
                break;
            end
        end
        if (done_at < 0) check("done_seen", done_at, done_cyc);
    endtask

    typedef struct {
        logic [14:0] a;
        logic [1:0]  l;
        int          d0, d1, d2, d3;
        int          exp_done;
        logic        exp_err;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   d[4];
        int   done_at;
        logic err_at;

        for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
        mem[15'h0010] = 8'hA5;
        mem[15'h0100] = 8'h11;
        mem[15'h0101] = 8'h22;
        mem[15'h0102] = 8'h33;
        mem[15'h0103] = 8'h44;

        tbl[0] = '{15'h0010, 2'd0, 0, 0, 0, 0,  3, 1'b0};
        tbl[1] = '{15'h0100, 2'd3, 0, 0, 0, 0,  9, 1'b0};
        tbl[2] = '{15'h7FFF, 2'd1, 0, 0, 0, 0,  5, 1'b0};
        tbl[3] = '{15'h1234, 2'd0, 15, 0, 0, 0, 16, 1'b1};
        tbl[4] = '{15'h0200, 2'd1, 4, 4, 0, 0, 13, 1'b0};
        tbl[5] = '{15'h0400, 2'd2, 0, 15, 0, 0, 18, 1'b1};

        rst       = 1'b1;
        start     = 1'b0;
        addr_in   = '0;
        len       = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        #1;
        check("rst_mem_rd", mem_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_mdr_we", {mdr_we, mdr_shift}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mdr_data", mdr_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            d = '{tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3};
            run_fetch(tbl[i].a, tbl[i].l, d, 1'b0, done_at, err_at);
            check($sformatf("tbl%0d_done", i), done_at, tbl[i].exp_done);
            check($sformatf("tbl%0d_err", i), err_at, tbl[i].exp_err);
        end
        check("tbl_last_mdr_hold", mdr_data, mem[15'h0400]);

        // err must survive into IDLE, then clear asynchronously on reset.
        repeat (2) @(negedge clk);
        check("err_sticky_idle", err, 1);
        check("idle_busy", busy, 0);
        #2 rst = 1'b1;
        #1 check("rst_clears_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a read abandons the fetch.
        d = '{0, 0, 0, 0};
        run_fetch(15'h0050, 2'd0, d, 1'b0, done_at, err_at);
        @(negedge clk);
        start   = 1'b1;
        addr_in = 15'h0300;
        len     = 2'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("midrd_mem_rd", mem_rd, 1);
        check("midrd_addr", mem_addr, 15'h0300);
        #2 rst = 1'b1;
        #1;
        check("midrst_mem_rd", mem_rd, 0);
        check("midrst_busy", busy, 0);
        check("midrst_strobes", {mdr_we, mdr_shift, done}, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_mdr_data", mdr_data, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            check("post_rst_quiet", {busy, mdr_we, done}, 0);
        end
        mem_ready = 1'b0;

        for (int r = 0; r < 40; r++) begin
            logic [14:0] a;
            logic [1:0]  l;
            a = ($urandom_range(0, 3) == 0) ? 15'($urandom_range(32765, 32767)) : 15'($urandom);
            l = 2'($urandom);
            for (int k = 0; k < 4; k++)
                d[k] = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 5);
            run_fetch(a, l, d, 1'b1, done_at, err_at);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_fetch_seq.md
MEM_FETCH_SEQ -- requirements
Module: mem_fetch_seq

Interface
REQ-001 Parameter ADDR_W, default 15, SHALL set the address width to match the MDR address fields.
REQ-002 Parameter DATA_W, default 8, SHALL set the memory byte width to match the MDR in1 input.
REQ-003 Parameter TIMEOUT, default 15, SHALL set the maximum number of RD cycles spent waiting for mem_ready.
REQ-004 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-006 Port start  input  1  SHALL request a fetch; sampled only in IDLE.
REQ-007 Port addr_in  input  ADDR_W  SHALL carry the base byte address, captured with start.
REQ-008 Port len  input  2  SHALL carry the byte count minus one (1..4 bytes), captured with start.
REQ-009 Port mem_rdata  input  DATA_W  SHALL carry read data, valid when mem_ready=1.
REQ-010 Port mem_ready  input  1  SHALL be the memory read-complete strobe.
REQ-011 Port mem_addr  output  ADDR_W  SHALL carry the current byte address.
REQ-012 Port mem_rd  output  1  SHALL be the memory read request.
REQ-013 Port mdr_data  output  DATA_W  SHALL carry the registered byte to MDR in1.
REQ-014 Port mdr_we  output  1  SHALL be the MDR write strobe.
REQ-015 Port mdr_shift  output  1  SHALL be the MDR shift strobe.
REQ-016 Port busy  output  1  SHALL be high in every state except IDLE.
REQ-017 Port done  output  1  SHALL be a one-cycle completion pulse.
REQ-018 Port err  output  1  SHALL be a sticky timeout flag.

Function
REQ-019 The FSM SHALL have states IDLE, RD, LOAD, DONE, all outputs registered or state-decoded without combinational paths from inputs.
REQ-020 IDLE with start=1 SHALL capture addr_in to cur_addr, len to remaining, clear err, clear first-byte flag, and enter RD.
REQ-021 RD SHALL drive mem_rd=1 and mem_addr=cur_addr and increment a wait counter each cycle.
REQ-022 RD with mem_ready=1 SHALL register mem_rdata into mdr_data, reset the wait counter, and enter LOAD.
REQ-023 RD with mem_ready=0 and wait counter equal to TIMEOUT-1 SHALL set err=1 and enter DONE without further MDR writes.
REQ-024 LOAD SHALL assert mdr_we=1 for one cycle, with mdr_shift=1 on every byte except the first of a fetch.
REQ-025 LOAD with remaining=0 SHALL enter DONE; otherwise it SHALL decrement remaining, increment cur_addr modulo 2^ADDR_W (0x7FFF wraps to 0x0000), and enter RD.
REQ-026 DONE SHALL assert done=1 for exactly one cycle and return to IDLE.
REQ-027 With zero memory wait, done SHALL assert 2N+1 cycles after the start-sampling edge for an N-byte fetch.
REQ-028 start while busy=1 SHALL be ignored, with no queuing.
REQ-029 mem_ready outside RD SHALL be ignored.
REQ-030 err SHALL hold until the next accepted start or reset.

Reset
REQ-031 rst=1 SHALL immediately force IDLE and set mem_rd, mdr_we, mdr_shift, busy, done, and err to 0.
REQ-032 rst=1 SHALL immediately set mem_addr, mdr_data, and all counters to 0.
REQ-033 Reset asserted mid-fetch SHALL abandon the fetch with no done pulse and no further MDR strobes.

Structure
REQ-034 State encodings and default ADDR_W/DATA_W/TIMEOUT SHALL live in a shared package, cpu_pkg.
REQ-035 The block SHALL be a single module with no sub-modules, because the wait counter is too small to justify one.

Verification
REQ-036 Scenario: start, addr_in=0x0010, len=0, mem_ready immediate, rdata=0xA5 -> mem_addr=0x0010, mdr_data=0xA5, mdr_we once, mdr_shift=0, done at cycle 3.
REQ-037 Scenario: len=3 from 0x0100, rdata 0x11/0x22/0x33/0x44 -> addresses 0x0100..0x0103, four mdr_we pulses, mdr_shift on pulses 2-4 only, done at cycle 9.
REQ-038 Scenario: len=1 from 0x7FFF -> second read at 0x0000.
REQ-039 Scenario: mem_ready withheld -> 15 RD cycles, err=1, done pulse, no mdr_we; next start clears err.
REQ-040 Scenario: mem_ready delayed 4 cycles per byte, len=1 -> done at cycle 13, data correct.
REQ-041 Scenario: start pulsed while busy, and rst asserted during RD -> extra start ignored; rst gives outputs 0 at once and no done.
